// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and serial frame constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      UART_RX_IDLE  = 3'd0,
      UART_RX_START = 3'd1,
      UART_RX_DATA  = 3'd2,
      UART_RX_STOP  = 3'd3,
      UART_RX_BREAK = 3'd4
   } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous level into clk.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; continuous sampling.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Both stages reset to the line's idle value so reset never looks like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a single-entry valid/ready byte output.
// Latency: byte/frame_err/overrun appear 1 cycle after the mid-stop-bit sample.
// Backpressure: one holding register; a byte arriving while it is full and unconsumed is dropped with overrun_o.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_in,
   output logic [UART_DATA_BITS-1:0] data_o,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic                      frame_err_o,
   output logic                      overrun_o,
   output logic                      busy_o
);

   localparam int            CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

   // Fewer than 4 clocks per bit leaves no usable mid-bit sample point.
   if (CLKS_PER_BIT < 4) begin : g_cfg_check
      $error("uart_rx: CLKS_PER_BIT must be >= 4");
   end

   uart_rx_state_t            state, state_nxt;
   logic [CW-1:0]             cnt, cnt_nxt;
   logic [2:0]                bit_idx, idx_nxt;
   logic [UART_DATA_BITS-1:0] shreg, shreg_nxt;
   logic                      rxs;
   logic                      deliver;
   logic                      ferr;

   uart_sync2 #(
      .RESET_VAL (UART_IDLE_LEVEL)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rxs)
   );

   // FSM state, bit timer, bit index and shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= UART_RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= idx_nxt;
         shreg   <= shreg_nxt;
      end
   end

   // Next state: the timer free-runs and is cleared at every sample point.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      idx_nxt   = bit_idx;
      shreg_nxt = shreg;
      deliver   = 1'b0;
      ferr      = 1'b0;
      case (state)
         UART_RX_IDLE: begin
            cnt_nxt = '0;
            if (rxs != UART_IDLE_LEVEL) begin
               state_nxt = UART_RX_START;
            end
         end
         UART_RX_START: begin
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (rxs == UART_IDLE_LEVEL) begin
                  state_nxt = UART_RX_IDLE;   // glitch shorter than half a bit
               end else begin
                  state_nxt = UART_RX_DATA;
                  idx_nxt   = '0;
               end
            end
         end
         UART_RX_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               shreg_nxt = {rxs, shreg[UART_DATA_BITS-1:1]};
               idx_nxt   = bit_idx + 3'd1;
               if (bit_idx == IDX_LAST) begin
                  state_nxt = UART_RX_STOP;
               end
            end
         end
         UART_RX_STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (rxs == UART_IDLE_LEVEL) begin
                  deliver   = 1'b1;
                  state_nxt = UART_RX_IDLE;
               end else begin
                  ferr      = 1'b1;
                  state_nxt = UART_RX_BREAK;
               end
            end
         end
         UART_RX_BREAK: begin
            // Wait for the line to return high so a held-low line cannot retrigger.
            cnt_nxt = '0;
            if (rxs == UART_IDLE_LEVEL) begin
               state_nxt = UART_RX_IDLE;
            end
         end
         default: begin
            state_nxt = UART_RX_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Holding register, consumer handshake and one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= ferr;
         overrun_o   <= 1'b0;
         if (deliver) begin
            if (!valid_o || ready_i) begin
               data_o  <= shreg;
               valid_o <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

   assign busy_o = (state != UART_RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scoreboard of expected bytes plus event counters.
// Latency: checks stop-sample+1 delivery and start-sample+1 glitch recovery.
// Backpressure: exercises ready_i low (overrun) and release.
module tb_uart_rx;

   localparam int CPB = 16;
   // rx_in edge -> 2 sync flops -> IDLE detect cycle, then half a bit plus 9 full bits.
   localparam int LAT = 3 + CPB / 2 + 9 * CPB;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       rx_in   = 1'b1;
   logic       ready_i = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int n_ovr = 0;
   int last_valid_cyc = -1;
   int t0, v0, f0, o0;
   logic [7:0] exp_q[$];

   uart_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_in       (rx_in),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Inputs change 2 time units after a rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Drives one 8N1 frame LSB first; the line is left at the stop level.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic push);
      if (push) exp_q.push_back(b);
      rx_in = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_in = b[i];
         tick(CPB);
      end
      rx_in = stop;
      tick(CPB);
   endtask

   // Output monitor: counts events and scores handshaken bytes.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_o) begin
            n_valid++;
            last_valid_cyc = cyc;
         end
         if (frame_err_o) n_ferr++;
         if (overrun_o) n_ovr++;
         if (valid_o && ready_i) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rx_byte", 32'(data_o), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got t=%0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. Reset values, then asynchronous reset mid-frame with a byte held.
      tick(3);
      check("rst_data", 32'(data_o), 0);
      check("rst_valid", 32'(valid_o), 0);
      check("rst_ferr", 32'(frame_err_o), 0);
      check("rst_ovr", 32'(overrun_o), 0);
      check("rst_busy", 32'(busy_o), 0);
      rst_n = 1'b1;
      tick(4);
      ready_i = 1'b0;
      send_frame(8'h54, 1'b1, 1'b0);
      check("t1_pre_valid", 32'(valid_o), 1);
      rx_in = 1'b0;
      tick(20);
      check("t1_pre_busy", 32'(busy_o), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("t1_async_valid", 32'(valid_o), 0);
      check("t1_async_data", 32'(data_o), 0);
      check("t1_async_busy", 32'(busy_o), 0);
      rx_in = 1'b1;
      tick(1);
      rst_n = 1'b1;
      tick(4);

      // 2. Single byte with exact delivery cycle and one-cycle valid.
      ready_i = 1'b1;
      v0 = n_valid;
      t0 = cyc;
      send_frame(8'h54, 1'b1, 1'b1);
      tick(4);
      check("t2_valid_cycles", n_valid - v0, 1);
      check("t2_latency", last_valid_cyc - t0, LAT);

      // 3. Short low glitch is rejected at the start sample.
      v0 = n_valid;
      f0 = n_ferr;
      t0 = cyc;
      rx_in = 1'b0;
      tick(4);
      rx_in = 1'b1;
      while (cyc < t0 + 10) tick(1);
      check("t3_busy_at_sample", 32'(busy_o), 1);
      tick(1);
      check("t3_busy_after", 32'(busy_o), 0);
      tick(20);
      check("t3_no_valid", n_valid - v0, 0);
      check("t3_no_ferr", n_ferr - f0, 0);

      // 4. Framing error, line held low, then a good frame.
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(8'h41, 1'b0, 1'b0);
      tick(40);
      check("t4_break_busy", 32'(busy_o), 1);
      rx_in = 1'b1;
      tick(20);
      check("t4_ferr_count", n_ferr - f0, 1);
      check("t4_no_valid", n_valid - v0, 0);
      check("t4_idle", 32'(busy_o), 0);
      send_frame(8'h0D, 1'b1, 1'b1);
      tick(10);
      check("t4_good_valid", n_valid - v0, 1);

      // 5. Overrun with the consumer stalled, then release.
      ready_i = 1'b0;
      o0 = n_ovr;
      send_frame(8'h0D, 1'b1, 1'b1);
      send_frame(8'h0A, 1'b1, 1'b0);
      tick(10);
      check("t5_data_held", 32'(data_o), 32'h0D);
      check("t5_valid_held", 32'(valid_o), 1);
      check("t5_ovr_count", n_ovr - o0, 1);
      ready_i = 1'b1;
      tick(1);
      check("t5_valid_drop", 32'(valid_o), 0);

      // 6. Reset in the middle of data bit 3, then a clean frame.
      v0 = n_valid;
      fork
         send_frame(8'h5A, 1'b1, 1'b0);
         begin
            tick(CPB * 4 + CPB / 2);
            check("t6_busy_mid", 32'(busy_o), 1);
            #1;
            rst_n = 1'b0;
            #1;
            check("t6_busy_rst", 32'(busy_o), 0);
         end
      join
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check("t6_none_before", n_valid - v0, 0);
      send_frame(8'h0A, 1'b1, 1'b1);
      tick(10);
      check("t6_one_after", n_valid - v0, 1);

      // Back-to-back random bytes with a 1-bit stop.
      for (int i = 0; i < 4; i++) begin
         send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      end
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
      check("sb_drain", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
